vote_booth_scheduler: RTL and testbench
=======================================

# vote_booth_scheduler

Arbitrates up to NUM_BOOTH voting booths onto the single shared candidate-count datapath of the voting machine. It captures one vote request per booth, grants booths round-robin, checks that the booth was armed by the poll officer and that the candidate index is valid, and then emits a one-cycle increment strobe with the candidate select to the counter. After each increment it enforces a lockout hold, and it sequences the poll phases idle, open and closed.

## Interface
- NUM_BOOTH, 4, number of booths/requesters (2..8)
- NUM_CAND, 3, number of valid candidates; index range 0..NUM_CAND-1
- CAND_W, 2, width of candidate index
- COUNT_W, 16, width of accepted-vote total
- LOCK_CYCLES, 15, hold cycles after each accepted vote (>=1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_open  in  1  officer opens poll (level, acted on in IDLE)
- i_close  in  1  officer closes poll (level)
- i_arm  in  NUM_BOOTH  per-booth arm for one voter (level, sampled each cycle)
- i_req  in  NUM_BOOTH  per-booth vote request (rising edge significant)
- i_cand  in  NUM_BOOTH*CAND_W  per-booth candidate index; booth k at bits [k*CAND_W +: CAND_W]
- o_armed  out  NUM_BOOTH  booth currently armed
- o_ack  out  NUM_BOOTH  one-cycle pulse: vote accepted
- o_reject  out  NUM_BOOTH  one-cycle pulse: vote refused
- o_cnt_inc  out  1  one-cycle increment strobe to counter datapath
- o_cnt_sel  out  CAND_W  candidate to increment; valid when o_cnt_inc=1, else 0
- o_phase  out  2  00 IDLE, 01 OPEN (SCAN/ISSUE/HOLD), 11 CLOSED
- o_total  out  COUNT_W  accepted votes since open; saturates at all-ones

## Operation
- Reset (rst=0) drives every output to 0 and clears pending bits, captured candidates, armed bits, rr pointer (pointer=0) and the hold counter. State = IDLE.
- States: IDLE, SCAN, ISSUE, HOLD, CLOSED.
- IDLE: i_open=1 -> SCAN next cycle. o_total, armed and pending bits are cleared on that transition.
- Request capture runs in SCAN/ISSUE/HOLD only:
  - A rising edge of i_req[k] (registered previous value) with pending[k]=0 sets pending[k] and latches i_cand[k] the same edge.
  - Further edges while pending are ignored.
  - Edges in IDLE/CLOSED are discarded.
- Arming runs in SCAN/ISSUE/HOLD only: i_arm[k]=1 sets armed[k]. Arming an already-armed booth has no effect.
- SCAN, i_close=0, any pending: winner = first pending booth searching from pointer+1 upward, wrapping modulo NUM_BOOTH. Next state ISSUE.
- ISSUE (one cycle, winner w):
  - Accept if armed[w]=1 and cand<NUM_CAND: o_cnt_inc=1, o_cnt_sel=cand, o_ack[w]=1, armed[w] cleared, pending[w] cleared, o_total+1 (saturating), pointer=w. Next HOLD with counter=LOCK_CYCLES.
  - Otherwise reject: o_reject[w]=1, pending[w] cleared, pointer=w, no count, armed unchanged. Next SCAN.
- HOLD: decrement counter each cycle; at 1 -> SCAN. No grants during HOLD; captures continue.
- i_close=1 in SCAN -> CLOSED. i_close in ISSUE or HOLD is honoured at the next SCAN: the current vote and its full hold always complete.
- CLOSED: all pending and armed bits cleared on entry. o_total frozen. i_open ignored. Only rst leaves CLOSED.
- i_open and i_close both high in IDLE: go to SCAN. The close then acts in the first SCAN cycle, giving IDLE->SCAN->CLOSED.

## Timing
- Request edge at cycle t (sampled) -> pending at t+1 -> if SCAN and winner, ISSUE at t+2 (o_ack/o_cnt_inc high that cycle).
- Accepted vote occupies 1+LOCK_CYCLES cycles before the next grant. A rejected vote occupies 1 cycle.
- All outputs are registered. o_ack, o_reject and o_cnt_inc are never high for more than one cycle, and at most one booth bit is high per cycle.
- Asynchronous reset mid-ISSUE aborts the strobe: o_cnt_inc falls immediately with rst.

## Test plan
- Reset, i_open, arm booth 2, i_cand[2]=1, pulse i_req[2] -> o_ack[2] and o_cnt_inc with o_cnt_sel=1 two cycles after the edge, o_total=1, o_armed[2]=0, next grant is no earlier than 15 cycles later.
- Pulse i_req[0] without arming -> o_reject[0] pulse, o_cnt_inc stays 0, o_total unchanged, back in SCAN the next cycle.
- Arm booths 0,1,3 and raise all three requests in the same cycle, starting with pointer=0 -> grant order 1,3,0, three acks, o_total=3.
- Armed booth 1 with i_cand=3 (NUM_CAND=3) -> o_reject[1], o_armed[1] stays 1.
- Assert i_close during HOLD of an accepted vote -> hold completes, then o_phase=11, o_total frozen, later requests and i_open ignored.
- Hold i_req[2] high continuously after an ack and re-arm -> no second vote until i_req[2] falls and rises again. Assert rst during ISSUE -> all outputs 0 immediately.

Source files
------------

// File: rtl/vote_booth_if.sv
// rtl/vote_booth_if.sv - officer/booth/counter signal bundle for vote_booth_scheduler
//
// Purpose: groups the poll-control, per-booth request and counter-strobe
// signals so the scheduler and its environment connect through one port.
// Signals (directions seen from the scheduler, i.e. the slave modport):
//   i_open, i_close : officer poll controls (levels)
//   i_arm           : per-booth arm (level)
//   i_req           : per-booth vote request (rising edge significant)
//   i_cand          : per-booth candidate index, booth k at [k*CAND_W +: CAND_W]
//   o_armed         : booth currently armed
//   o_ack, o_reject : one-cycle per-booth result pulses
//   o_cnt_inc       : one-cycle increment strobe to the counter datapath
//   o_cnt_sel       : candidate to increment (0 when o_cnt_inc=0)
//   o_phase         : 00 idle, 01 open, 11 closed
//   o_total         : accepted votes since open, saturating
interface vote_booth_if #(
  parameter int NUM_BOOTH = 4,
  parameter int CAND_W    = 2,
  parameter int COUNT_W   = 16
) ();
  logic                          i_open;
  logic                          i_close;
  logic [NUM_BOOTH-1:0]          i_arm;
  logic [NUM_BOOTH-1:0]          i_req;
  logic [NUM_BOOTH*CAND_W-1:0]   i_cand;
  logic [NUM_BOOTH-1:0]          o_armed;
  logic [NUM_BOOTH-1:0]          o_ack;
  logic [NUM_BOOTH-1:0]          o_reject;
  logic                          o_cnt_inc;
  logic [CAND_W-1:0]             o_cnt_sel;
  logic [1:0]                    o_phase;
  logic [COUNT_W-1:0]            o_total;

  modport master (
    output i_open, i_close, i_arm, i_req, i_cand,
    input  o_armed, o_ack, o_reject, o_cnt_inc, o_cnt_sel, o_phase, o_total
  );

  modport slave (
    input  i_open, i_close, i_arm, i_req, i_cand,
    output o_armed, o_ack, o_reject, o_cnt_inc, o_cnt_sel, o_phase, o_total
  );
endinterface

// File: rtl/vote_booth_scheduler.sv
// rtl/vote_booth_scheduler.sv - round-robin booth arbiter feeding the shared vote counter
//
// Purpose: captures one vote request per booth, grants booths round-robin,
// validates arming and candidate index, emits a one-cycle increment strobe,
// enforces a lockout hold after every accepted vote and sequences the poll
// phases idle -> open -> closed.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : vote_booth_if slave modport (controls, requests, results, counter strobe)
module vote_booth_scheduler #(
  parameter int NUM_BOOTH   = 4,
  parameter int NUM_CAND    = 3,
  parameter int CAND_W      = 2,
  parameter int COUNT_W     = 16,
  parameter int LOCK_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  vote_booth_if.slave bus
);

  localparam int PTR_W  = (NUM_BOOTH > 1) ? $clog2(NUM_BOOTH) : 1;
  localparam int HOLD_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_CLOSED = 3'd4;

  // state and bookkeeping
  logic [2:0]           r_state;
  logic [NUM_BOOTH-1:0] r_req_prev;
  logic [NUM_BOOTH-1:0] r_pending;
  logic [NUM_BOOTH-1:0] r_armed;
  logic [CAND_W-1:0]    r_cand [NUM_BOOTH];
  logic [PTR_W-1:0]     r_ptr;
  logic [HOLD_W-1:0]    r_hold;

  // registered outputs
  logic [NUM_BOOTH-1:0] r_ack;
  logic [NUM_BOOTH-1:0] r_reject;
  logic                 r_cnt_inc;
  logic [CAND_W-1:0]    r_cnt_sel;
  logic [1:0]           r_phase;
  logic [COUNT_W-1:0]   r_total;

  // combinational helpers
  logic                 w_active;
  logic [NUM_BOOTH-1:0] w_rise;
  logic [NUM_BOOTH-1:0] w_capture;
  logic                 w_found;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W:0]       w_sum;
  logic [CAND_W-1:0]    w_win_cand;
  logic                 w_accept;
  logic                 w_grant;
  logic                 w_close_now;
  logic [2:0]           w_next;
  logic [NUM_BOOTH-1:0] w_pending_nxt;
  logic [NUM_BOOTH-1:0] w_armed_nxt;
  logic [1:0]           w_phase_nxt;

  assign w_active = (r_state == S_SCAN) || (r_state == S_ISSUE) || (r_state == S_HOLD);

  // A capture needs a fresh rising edge and a free pending slot; edges seen
  // outside the open phase are simply dropped.
  assign w_rise    = bus.i_req & ~r_req_prev;
  assign w_capture = w_active ? (w_rise & ~r_pending) : '0;

  // Round-robin search starting one past the last served booth. The sum is
  // one bit wider than the pointer so the wrap works for any NUM_BOOTH.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 1; i <= NUM_BOOTH; i++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_BOOTH)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_BOOTH);
      end
      if (!w_found && r_pending[w_sum[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PTR_W-1:0];
      end
    end
  end

  assign w_win_cand  = r_cand[w_win];
  assign w_accept    = r_armed[w_win] && ({1'b0, w_win_cand} < (CAND_W+1)'(NUM_CAND));
  // Close only takes effect in SCAN, so an issued vote always finishes its hold.
  assign w_close_now = (r_state == S_SCAN) && bus.i_close;
  assign w_grant     = (r_state == S_SCAN) && !bus.i_close && w_found;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_open) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (bus.i_close)  w_next = S_CLOSED;
        else if (w_found) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        // r_cnt_inc is high exactly during the ISSUE cycle of an accepted vote
        w_next = r_cnt_inc ? S_HOLD : S_SCAN;
      end
      S_HOLD: begin
        if (r_hold <= HOLD_W'(1)) w_next = S_SCAN;
      end
      S_CLOSED: begin
        w_next = S_CLOSED;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Pending/armed bookkeeping. A booth granted this edge loses its pending
  // bit; an accepted booth loses its arm even if i_arm is still high, so a
  // held arm level re-arms only on the following edge.
  always_comb begin
    w_pending_nxt = r_pending;
    w_armed_nxt   = r_armed;
    if ((r_state == S_IDLE) && bus.i_open) begin
      w_pending_nxt = '0;
      w_armed_nxt   = '0;
    end else if (w_close_now || (r_state == S_CLOSED)) begin
      w_pending_nxt = '0;
      w_armed_nxt   = '0;
    end else if (w_active) begin
      w_pending_nxt = r_pending | w_capture;
      w_armed_nxt   = r_armed | bus.i_arm;
      if (w_grant) begin
        w_pending_nxt[w_win] = 1'b0;
        if (w_accept) w_armed_nxt[w_win] = 1'b0;
      end
    end
  end

  always_comb begin
    case (w_next)
      S_SCAN, S_ISSUE, S_HOLD: w_phase_nxt = 2'b01;
      S_CLOSED:                w_phase_nxt = 2'b11;
      default:                 w_phase_nxt = 2'b00;
    endcase
  end

  // Grant effects are registered on the SCAN->ISSUE edge so the strobe,
  // ack/reject and the updated total are all visible during the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req_prev <= '0;
      r_pending  <= '0;
      r_armed    <= '0;
      for (int k = 0; k < NUM_BOOTH; k++) r_cand[k] <= '0;
      r_ptr      <= '0;
      r_hold     <= '0;
      r_ack      <= '0;
      r_reject   <= '0;
      r_cnt_inc  <= 1'b0;
      r_cnt_sel  <= '0;
      r_phase    <= 2'b00;
      r_total    <= '0;
    end else begin
      r_state    <= w_next;
      r_req_prev <= bus.i_req;
      r_pending  <= w_pending_nxt;
      r_armed    <= w_armed_nxt;
      r_phase    <= w_phase_nxt;
      r_ack      <= '0;
      r_reject   <= '0;
      r_cnt_inc  <= 1'b0;
      r_cnt_sel  <= '0;

      for (int k = 0; k < NUM_BOOTH; k++) begin
        if (w_capture[k]) r_cand[k] <= bus.i_cand[k*CAND_W +: CAND_W];
      end

      if ((r_state == S_IDLE) && bus.i_open) r_total <= '0;

      if (w_grant) begin
        r_ptr <= w_win;
        if (w_accept) begin
          r_ack[w_win] <= 1'b1;
          r_cnt_inc    <= 1'b1;
          r_cnt_sel    <= w_win_cand;
          if (r_total != '1) r_total <= r_total + COUNT_W'(1);
        end else begin
          r_reject[w_win] <= 1'b1;
        end
      end

      if ((r_state == S_ISSUE) && r_cnt_inc) begin
        r_hold <= HOLD_W'(LOCK_CYCLES);
      end else if ((r_state == S_HOLD) && (r_hold != '0)) begin
        r_hold <= r_hold - HOLD_W'(1);
      end
    end
  end

  assign bus.o_armed   = r_armed;
  assign bus.o_ack     = r_ack;
  assign bus.o_reject  = r_reject;
  assign bus.o_cnt_inc = r_cnt_inc;
  assign bus.o_cnt_sel = r_cnt_sel;
  assign bus.o_phase   = r_phase;
  assign bus.o_total   = r_total;

endmodule

// File: tb/tb_vote_booth_scheduler.sv
// tb/tb_vote_booth_scheduler.sv - self-checking bench for vote_booth_scheduler
module tb_vote_booth_scheduler;
  localparam int NB   = 4;
  localparam int NC   = 3;
  localparam int CW   = 2;
  localparam int CTW  = 16;
  localparam int LOCK = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  vote_booth_if #(.NUM_BOOTH(NB), .CAND_W(CW), .COUNT_W(CTW)) vif ();

  vote_booth_scheduler #(
    .NUM_BOOTH(NB), .NUM_CAND(NC), .CAND_W(CW), .COUNT_W(CTW), .LOCK_CYCLES(LOCK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: poll phase, per-booth bookkeeping and a "cycles until
  // the next grant opportunity" count (accept: 1 + LOCK, reject: 1).
  int           m_phase;
  bit [NB-1:0]  m_pend, m_arm, m_prev;
  int           m_cand [NB];
  int           m_ptr, m_total, m_wait;
  bit [NB-1:0]  e_ack, e_rej;
  bit           e_inc;
  int           e_sel;

  task automatic model_reset();
    m_phase = 0; m_pend = '0; m_arm = '0; m_prev = '0;
    for (int k = 0; k < NB; k++) m_cand[k] = 0;
    m_ptr = 0; m_total = 0; m_wait = 0;
    e_ack = '0; e_rej = '0; e_inc = 0; e_sel = 0;
  endtask

  task automatic model_edge();
    bit [NB-1:0] req, arm, rise, old_pend;
    bit found, acc;
    int w;
    req = vif.i_req; arm = vif.i_arm;
    e_ack = '0; e_rej = '0; e_inc = 0; e_sel = 0;
    if (m_phase == 0) begin
      if (vif.i_open) begin
        m_phase = 1; m_total = 0; m_arm = '0; m_pend = '0; m_wait = 0;
      end
    end else if (m_phase == 1) begin
      rise = req & ~m_prev;
      old_pend = m_pend;
      if (m_wait == 0 && vif.i_close) begin
        m_phase = 3; m_pend = '0; m_arm = '0;
      end else begin
        found = 0; acc = 0; w = 0;
        if (m_wait == 0) begin
          for (int i = 1; i <= NB; i++) begin
            if (!found && m_pend[(m_ptr + i) % NB]) begin
              found = 1; w = (m_ptr + i) % NB;
            end
          end
        end
        if (found) begin
          acc = m_arm[w] && (m_cand[w] < NC);
          m_pend[w] = 0;
          m_ptr = w;
          if (acc) begin
            e_ack[w] = 1; e_inc = 1; e_sel = m_cand[w];
            if (m_total < (1 << CTW) - 1) m_total++;
            m_wait = 1 + LOCK;
          end else begin
            e_rej[w] = 1;
            m_wait = 1;
          end
        end else if (m_wait > 0) begin
          m_wait--;
        end
        for (int k = 0; k < NB; k++) begin
          if (rise[k] && !old_pend[k]) begin
            m_pend[k] = 1;
            m_cand[k] = int'(vif.i_cand[k*CW +: CW]);
          end
        end
        m_arm = m_arm | arm;
        if (found && acc) m_arm[w] = 0;
      end
    end
    m_prev = req;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    vif.i_open = 0; vif.i_close = 0; vif.i_arm = '0; vif.i_req = '0; vif.i_cand = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic reset_open();
    do_reset();
    vif.i_open = 1;
    step();
    vif.i_open = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    #23;
    n_tests++;
    if ({vif.o_armed, vif.o_ack, vif.o_reject, vif.o_cnt_inc, vif.o_cnt_sel, vif.o_phase, vif.o_total} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b rej=%b inc=%b phase=%b total=%0d armed=%b, want all 0",
               vif.o_ack, vif.o_reject, vif.o_cnt_inc, vif.o_phase, vif.o_total, vif.o_armed);
    end
    do_reset();
    step();
    n_tests++;
    if (vif.o_phase !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle_phase: got %b want 00", vif.o_phase);
    end
  endtask

  task automatic test_single_vote();
    int gap;
    bit done;
    reset_open();
    vif.i_arm = 4'b0100; step(); vif.i_arm = '0;
    n_tests++;
    if (vif.o_armed !== 4'b0100) begin n_fail++; $display("FAIL single_armed: got %b want 0100", vif.o_armed); end
    vif.i_cand = 8'h10;
    vif.i_req = 4'b0100; step(); vif.i_req = '0;
    step();
    n_tests++;
    if ({vif.o_ack, vif.o_cnt_inc, vif.o_cnt_sel, vif.o_total, vif.o_armed} !== {4'b0100, 1'b1, 2'd1, 16'd1, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_ack: got ack=%b inc=%b sel=%0d total=%0d armed=%b want 0100/1/1/1/0000",
               vif.o_ack, vif.o_cnt_inc, vif.o_cnt_sel, vif.o_total, vif.o_armed);
    end
    gap = 0;
    vif.i_arm = 4'b1000; vif.i_req = 4'b1000; step(); gap++;
    vif.i_arm = '0; vif.i_req = '0;
    n_tests++;
    if ({vif.o_ack, vif.o_cnt_inc} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_pulse_width: got ack=%b inc=%b want 0", vif.o_ack, vif.o_cnt_inc);
    end
    done = 0;
    while (!done && gap < 60) begin
      step(); gap++;
      if (vif.o_ack != 0) done = 1;
    end
    n_tests++;
    if (vif.o_ack !== 4'b1000 || gap != LOCK + 2) begin
      n_fail++;
      $display("FAIL lockout_gap: got ack=%b after %0d cycles want 1000 after %0d", vif.o_ack, gap, LOCK + 2);
    end
  endtask

  task automatic test_reject_unarmed();
    reset_open();
    vif.i_req = 4'b0001; step();
    vif.i_req = 4'b0010; vif.i_arm = 4'b0010; vif.i_cand = 8'h08;
    step();
    vif.i_req = '0; vif.i_arm = '0;
    n_tests++;
    if ({vif.o_reject, vif.o_ack, vif.o_cnt_inc, vif.o_total} !== {4'b0001, 4'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reject_unarmed: got rej=%b ack=%b inc=%b total=%0d want 0001/0000/0/0",
               vif.o_reject, vif.o_ack, vif.o_cnt_inc, vif.o_total);
    end
    step();
    n_tests++;
    if ({vif.o_reject, vif.o_ack} !== 8'b0) begin
      n_fail++;
      $display("FAIL reject_pulse_width: got rej=%b ack=%b want 0", vif.o_reject, vif.o_ack);
    end
    step();
    n_tests++;
    if ({vif.o_ack, vif.o_cnt_sel, vif.o_total} !== {4'b0010, 2'd2, 16'd1}) begin
      n_fail++;
      $display("FAIL reject_one_cycle: got ack=%b sel=%0d total=%0d want 0010/2/1", vif.o_ack, vif.o_cnt_sel, vif.o_total);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int got0, got1, got2;
    reset_open();
    vif.i_arm = 4'b1011; step(); vif.i_arm = '0;
    vif.i_req = 4'b1011; step(); vif.i_req = '0;
    for (int c = 0; c < 80; c++) begin
      step();
      for (int k = 0; k < NB; k++) if (vif.o_ack[k]) order.push_back(k);
    end
    got0 = (order.size() > 0) ? order[0] : 9;
    got1 = (order.size() > 1) ? order[1] : 9;
    got2 = (order.size() > 2) ? order[2] : 9;
    n_tests++;
    if (order.size() != 3 || got0 != 1 || got1 != 3 || got2 != 0) begin
      n_fail++;
      $display("FAIL rr_order: got %0d acks order %0d,%0d,%0d want 1,3,0", order.size(), got0, got1, got2);
    end
    n_tests++;
    if (vif.o_total !== 16'd3) begin n_fail++; $display("FAIL rr_total: got %0d want 3", vif.o_total); end
  endtask

  task automatic test_bad_cand();
    reset_open();
    vif.i_arm = 4'b0010; step(); vif.i_arm = '0;
    vif.i_cand = 8'h0C;
    vif.i_req = 4'b0010; step(); vif.i_req = '0;
    step();
    n_tests++;
    if ({vif.o_reject, vif.o_ack, vif.o_cnt_inc, vif.o_armed, vif.o_total} !== {4'b0010, 4'b0, 1'b0, 4'b0010, 16'd0}) begin
      n_fail++;
      $display("FAIL bad_cand: got rej=%b ack=%b inc=%b armed=%b total=%0d want 0010/0000/0/0010/0",
               vif.o_reject, vif.o_ack, vif.o_cnt_inc, vif.o_armed, vif.o_total);
    end
  endtask

  task automatic test_close_in_hold();
    int gap;
    bit [NB-1:0] seen;
    reset_open();
    vif.i_arm = 4'b0001; vif.i_req = 4'b0001; step();
    vif.i_arm = '0; vif.i_req = '0;
    step();
    n_tests++;
    if (vif.o_ack !== 4'b0001) begin n_fail++; $display("FAIL close_setup_ack: got %b want 0001", vif.o_ack); end
    vif.i_close = 1;
    gap = 0;
    while (vif.o_phase !== 2'b11 && gap < 60) begin step(); gap++; end
    n_tests++;
    if (vif.o_phase !== 2'b11 || gap != LOCK + 2 || vif.o_total !== 16'd1) begin
      n_fail++;
      $display("FAIL close_after_hold: got phase=%b after %0d cycles total=%0d want 11 after %0d total=1",
               vif.o_phase, gap, vif.o_total, LOCK + 2);
    end
    vif.i_close = 0; vif.i_open = 1; vif.i_arm = 4'b1111; vif.i_req = 4'b1111;
    step();
    vif.i_req = '0;
    seen = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      seen = seen | vif.o_ack | vif.o_reject;
    end
    vif.i_open = 0; vif.i_arm = '0;
    n_tests++;
    if ({seen, vif.o_phase, vif.o_total, vif.o_armed} !== {4'b0, 2'b11, 16'd1, 4'b0}) begin
      n_fail++;
      $display("FAIL closed_frozen: got acts=%b phase=%b total=%0d armed=%b want 0000/11/1/0000",
               seen, vif.o_phase, vif.o_total, vif.o_armed);
    end
  endtask

  task automatic test_open_close_idle();
    do_reset();
    vif.i_open = 1; vif.i_close = 1;
    step();
    n_tests++;
    if (vif.o_phase !== 2'b01) begin n_fail++; $display("FAIL open_close_first: got %b want 01", vif.o_phase); end
    step();
    n_tests++;
    if (vif.o_phase !== 2'b11) begin n_fail++; $display("FAIL open_close_second: got %b want 11", vif.o_phase); end
    clear_inputs();
  endtask

  task automatic test_held_request();
    bit [NB-1:0] seen;
    bit done;
    reset_open();
    vif.i_arm = 4'b0100; step(); vif.i_arm = '0;
    vif.i_cand = 8'h10;
    vif.i_req = 4'b0100; step();
    step();
    n_tests++;
    if (vif.o_ack !== 4'b0100) begin n_fail++; $display("FAIL held_first_ack: got %b want 0100", vif.o_ack); end
    vif.i_arm = 4'b0100; step(); vif.i_arm = '0;
    seen = '0;
    for (int c = 0; c < 40; c++) begin step(); seen = seen | vif.o_ack | vif.o_reject; end
    n_tests++;
    if ({seen, vif.o_armed} !== {4'b0, 4'b0100}) begin
      n_fail++;
      $display("FAIL held_no_revote: got acts=%b armed=%b want 0000/0100", seen, vif.o_armed);
    end
    vif.i_req = '0; step();
    vif.i_req = 4'b0100; step();
    vif.i_req = '0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin step(); if (vif.o_ack != 0) done = 1; end
    n_tests++;
    if (vif.o_ack !== 4'b0100 || vif.o_total !== 16'd2) begin
      n_fail++;
      $display("FAIL held_second_vote: got ack=%b total=%0d want 0100/2", vif.o_ack, vif.o_total);
    end
  endtask

  task automatic test_reset_in_issue();
    bit hit;
    reset_open();
    vif.i_arm = 4'b0010; vif.i_req = 4'b0010; step();
    vif.i_arm = '0; vif.i_req = '0;
    hit = 0;
    for (int c = 0; c < 10 && !hit; c++) begin step(); if (vif.o_cnt_inc === 1'b1) hit = 1; end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL issue_reached: got no strobe want o_cnt_inc=1"); end
    rst = 0;
    #1;
    n_tests++;
    if ({vif.o_armed, vif.o_ack, vif.o_reject, vif.o_cnt_inc, vif.o_cnt_sel, vif.o_phase, vif.o_total} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_issue: got ack=%b inc=%b phase=%b total=%0d want all 0",
               vif.o_ack, vif.o_cnt_inc, vif.o_phase, vif.o_total);
    end
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vif.i_open  = (cyc == 0) || ($urandom_range(0, 9) == 0);
      vif.i_close = (cyc > 2500) && ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NB; k++) begin
        vif.i_arm[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) vif.i_req[k] = ~vif.i_req[k];
      end
      vif.i_cand = NB*CW'($urandom);
      step();
      n_tests++;
      if ({vif.o_ack, vif.o_reject, vif.o_cnt_inc, vif.o_cnt_sel, vif.o_phase, vif.o_armed, vif.o_total} !==
          {e_ack, e_rej, e_inc, CW'(e_sel), 2'(m_phase), m_arm, CTW'(m_total)}) begin
        n_fail++;
        bad++;
        if (bad <= 8)
          $display("FAIL random_cycle_%0d: got ack=%b rej=%b inc=%b sel=%0d ph=%b arm=%b tot=%0d want %b %b %b %0d %b %b %0d",
                   cyc, vif.o_ack, vif.o_reject, vif.o_cnt_inc, vif.o_cnt_sel, vif.o_phase, vif.o_armed, vif.o_total,
                   e_ack, e_rej, e_inc, e_sel, 2'(m_phase), m_arm, m_total);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single_vote();
    test_reject_unarmed();
    test_round_robin();
    test_bad_cand();
    test_close_in_hold();
    test_open_close_idle();
    test_held_request();
    test_reset_in_issue();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
